aux_uart_boot_loader: RTL and testbench

AUX_UART_BOOT_LOADER -- requirements
Module: aux_uart_boot_loader

---
 rtl/aux_uart_boot_loader.sv | 215 +++++++++++++++++++++
 tb/tb_aux_uart_boot_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aux_uart_boot_loader.sv
// Aux UART boot loader: 8N1 bytes (8E1 when AUX_UART_PARITY_EN is defined) packed little-endian into 32-bit word writes.
// Latency: boot_valid pulses the cycle after the 4th byte's stop sample; boot_addr advances the cycle after that.
// Backpressure: none; writes are strobed and must be absorbed by the sink, and rx cannot be stalled.
module aux_uart_boot_loader #(
    parameter int CLK_FREQUENCY  = 50000000,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int ADDR_W         = 14
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              rx,
    output logic              boot_valid,
    output logic [ADDR_W-1:0] boot_addr,
    output logic [31:0]       boot_data,
    output logic              boot_busy,
    output logic              frame_err
);

    localparam int DIV    = CLK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W  = $clog2(DIV) + 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(DIV / 2 - 1);
    localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef AUX_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_rx_meta;
    logic                r_rx_sync;
    logic                r_rx_prev;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_end;
    logic                w_tick;
    logic                w_fall;
    logic                w_accept;
    logic                w_reject;
    logic                w_par_ok;
    logic [IDLE_W-1:0]   r_idle;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic [1:0]          r_byte;
    logic [31:0]         r_data;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_valid;
    logic                r_ferr;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_sync;

`ifdef AUX_UART_PARITY_EN
    logic r_par_bad;

    // Even parity: the parity bit must equal the XOR of the eight data bits.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_par_bad <= 1'b0;
        end else if (r_state == S_PARITY && w_tick) begin
            r_par_bad <= r_rx_sync ^ (^r_shift);
        end
    end

    assign w_par_ok = ~r_par_bad;
`else
    assign w_par_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and byte accept/reject decode; the start bit is sampled at half a bit time.
    always_comb begin
        w_next   = r_state;
        w_end    = (r_state == S_START) ? HALF_END : BIT_END;
        w_tick   = (r_cnt == w_end);
        w_accept = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A start edge beats a simultaneous timeout.
                if (w_fall) begin
                    w_next = S_START;
                end else if (r_idle == IDLE_END) begin
                    w_next = S_DONE;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_next = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && r_bit == 3'd7) begin
`ifdef AUX_UART_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
`ifdef AUX_UART_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    w_next   = S_IDLE;
                    w_accept = r_rx_sync & w_par_ok;
                    w_reject = ~(r_rx_sync & w_par_ok);
                end
            end
            S_DONE: begin
                w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bit timing, idle timeout counting and deserialisation.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_cnt   <= '0;
            r_idle  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == S_IDLE || r_state == S_DONE || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_IDLE) begin
                if (w_fall) begin
                    r_idle <= '0;
                end else if (r_idle != IDLE_END) begin
                    r_idle <= r_idle + IDLE_W'(1);
                end
            end
            if (r_state == S_START) begin
                r_bit <= '0;
            end else if (r_state == S_DATA && w_tick) begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end
        end
    end

    // Word assembly, write strobe, address advance and sticky framing error.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_byte  <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_accept && (r_byte == 2'd3);
            if (w_accept) begin
                r_data[{r_byte, 3'b000} +: 8] <= r_shift;
                r_byte <= r_byte + 2'd1;
            end
            if (w_reject) begin
                r_ferr <= 1'b1;
            end
            // A partial word left at timeout is dropped.
            if (r_state == S_IDLE && w_next == S_DONE) begin
                r_byte <= '0;
            end
            if (r_valid) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign boot_valid = r_valid;
    assign boot_addr  = r_addr;
    assign boot_data  = r_data;
    assign boot_busy  = (r_state != S_DONE);
    assign frame_err  = r_ferr;

endmodule

// File: tb/tb_aux_uart_boot_loader.sv
// Bench for aux_uart_boot_loader: UART byte driver, word-level reference model, write monitor.
// Latency: writes are matched in order against the model queue, with no fixed cycle offset.
// Backpressure: none; the monitor flags any write the model did not predict.
module tb_aux_uart_boot_loader;

    localparam int DIV = 16;
    localparam int TMO = 1000;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          rx = 1'b1;
    logic          boot_valid;
    logic [AW-1:0] boot_addr;
    logic [31:0]   boot_data;
    logic          boot_busy;
    logic          frame_err;

    always #5 clk = ~clk;

    aux_uart_boot_loader #(
        .CLK_FREQUENCY (1600000),
        .BAUD_RATE     (100000),
        .TIMEOUT_CYCLES(TMO),
        .ADDR_W        (AW)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .rx        (rx),
        .boot_valid(boot_valid),
        .boot_addr (boot_addr),
        .boot_data (boot_data),
        .boot_busy (boot_busy),
        .frame_err (frame_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: accepted bytes collect into a word; every fourth makes a write.
    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] pend[$];
    int         m_wr = 0;
    logic       m_ferr = 1'b0;
    int         n_pulse = 0;

    function automatic void expect_word(input logic [31:0] d);
        wr_t e;
        e.addr = AW'(m_wr % (1 << AW));
        e.data = d;
        exp_q.push_back(e);
        m_wr++;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic ok);
        logic [31:0] w;
        if (!ok) begin
            m_ferr = 1'b1;
        end else begin
            pend.push_back(b);
            if (pend.size() == 4) begin
                w = 32'(pend[0]) + 32'(pend[1]) * 256 + 32'(pend[2]) * 65536 + 32'(pend[3]) * 16777216;
                expect_word(w);
                pend.delete();
            end
        end
    endfunction

    function automatic void model_reset();
        pend.delete();
        exp_q.delete();
        m_wr   = 0;
        m_ferr = 1'b0;
    endfunction

    // Write monitor: each pulse must match the next predicted write, last one cycle, then bump the address.
    wr_t           mon_e;
    logic          chk_next = 1'b0;
    logic [AW-1:0] last_addr = '0;

    always @(negedge clk) begin
        if (chk_next) begin
            chk_next = 1'b0;
            check("valid_one_cycle", 32'(boot_valid), 32'd0);
            check("addr_incr", 32'(boot_addr), 32'((int'(last_addr) + 1) % (1 << AW)));
        end
        if (boot_valid) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                check("pulse_expected", 32'(boot_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_data", boot_data, mon_e.data);
                check("write_addr", 32'(boot_addr), 32'(mon_e.addr));
                last_addr = mon_e.addr;
                chk_next  = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
`ifdef AUX_UART_PARITY_EN
        rx = ^b;
        tick(DIV);
`endif
        rx = stop_ok;
        tick(DIV);
        rx = 1'b1;
        tick(gap);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            tick(1);
            t++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        tick(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(boot_valid), 32'd0);
        check({tag, "_addr"},  32'(boot_addr),  32'd0);
        check({tag, "_data"},  boot_data,       32'd0);
        check({tag, "_busy"},  32'(boot_busy),  32'd1);
        check({tag, "_ferr"},  32'(frame_err),  32'd0);
    endtask

    typedef struct {
        logic [7:0]  b [4];
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic       rok;
        int         t;

        tbl[0].b = '{8'h78, 8'h56, 8'h34, 8'h12}; tbl[0].exp = 32'h12345678;
        tbl[1].b = '{8'h00, 8'h00, 8'h00, 8'h00}; tbl[1].exp = 32'h00000000;
        tbl[2].b = '{8'hff, 8'hff, 8'hff, 8'hff}; tbl[2].exp = 32'hffffffff;
        tbl[3].b = '{8'h01, 8'h80, 8'hfe, 8'h7f}; tbl[3].exp = 32'h7ffe8001;

        resetb = 1'b0;
        rx     = 1'b1;
        tick(5);
        check_reset_outputs("reset");
        resetb = 1'b1;
        tick(3);

        // Fixed words, the first one landing at address 0.
        for (int v = 0; v < 4; v++) begin
            expect_word(tbl[v].exp);
            for (int k = 0; k < 4; k++) begin
                send_byte(tbl[v].b[k], 1'b1, 3);
            end
            wait_drain("table_drain");
        end

        // Short low glitch is a false start and produces no byte.
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(24);
        check("false_start_ferr", 32'(frame_err), 32'd0);
        expect_word(32'h3cc35aa5);
        send_byte(8'ha5, 1'b1, 3);
        send_byte(8'h5a, 1'b1, 3);
        send_byte(8'hc3, 1'b1, 3);
        send_byte(8'h3c, 1'b1, 3);
        wait_drain("false_start_drain");

        // Bad stop bit discards the byte without moving the byte index.
        send_byte(8'h55, 1'b0, 4);
        m_ferr = 1'b1;
        check("ferr_set", 32'(frame_err), 32'd1);
        expect_word(32'hdeadbeef);
        send_byte(8'hef, 1'b1, 3);
        send_byte(8'hbe, 1'b1, 3);
        send_byte(8'had, 1'b1, 3);
        send_byte(8'hde, 1'b1, 3);
        wait_drain("bad_stop_drain");
        check("ferr_sticky", 32'(frame_err), 32'd1);

        // Random bytes with occasional bad stop bits until 17 writes, wrapping the address.
        while (m_wr < 17) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 7) != 0);
            model_byte(rb, rok);
            send_byte(rb, rok, $urandom_range(2, 6));
        end
        wait_drain("random_drain");
        check("pulse_count", 32'(n_pulse), 32'd17);
        check("addr_after_wrap", 32'(boot_addr), 32'(m_wr % (1 << AW)));
        check("ferr_model", 32'(frame_err), 32'(m_ferr));
        check("busy_during_boot", 32'(boot_busy), 32'd1);

        // Reset in the middle of the third byte of a word.
        send_byte(8'h11, 1'b1, 3);
        send_byte(8'h22, 1'b1, 3);
        rx = 1'b0;
        tick(DIV);
        rx = 1'b1;
        tick(DIV * 3);
        resetb = 1'b0;
        model_reset();
        tick(2);
        check_reset_outputs("midword_reset");
        rx = 1'b1;
        tick(2);
        resetb = 1'b1;
        tick(3);
        expect_word(32'h44332211);
        send_byte(8'h11, 1'b1, 3);
        send_byte(8'h22, 1'b1, 3);
        send_byte(8'h33, 1'b1, 3);
        send_byte(8'h44, 1'b1, 3);
        wait_drain("after_reset_drain");

        // Two bytes then silence: the partial word is dropped and boot ends.
        model_byte(8'h01, 1'b1);
        send_byte(8'h01, 1'b1, 2);
        model_byte(8'h02, 1'b1);
        send_byte(8'h02, 1'b1, 1);
        pend.delete();
        tick(TMO - 120);
        check("busy_before_timeout", 32'(boot_busy), 32'd1);
        t = 0;
        while (boot_busy && t < 300) begin
            tick(1);
            t++;
        end
        check("busy_dropped", 32'(boot_busy), 32'd0);

        // DONE ignores further traffic.
        send_byte(8'h10, 1'b1, 3);
        send_byte(8'h11, 1'b1, 3);
        send_byte(8'h12, 1'b1, 3);
        send_byte(8'h13, 1'b1, 3);
        tick(40);
        check("done_terminal", 32'(boot_busy), 32'd0);
        check("done_addr_hold", 32'(boot_addr), 32'(m_wr % (1 << AW)));
        check("done_no_writes", 32'(n_pulse), 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
